// File: rtl/cr16_pkg.sv
// cr16_pkg: states, opcode/ext encodings, ALU codes, PSR bits and condition codes for cr16_control_fsm
package cr16_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EX_ALU, EX_SHIFT, MEM_LOAD, MEM_STORE, WB_REG, WB_LOAD, PC_UPD
  } stateT;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_CMP = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_MOV = 4'd6;
  localparam logic [3:0] ALU_LUI = 4'd7;
  localparam logic [3:0] ALU_NOP = 4'd15;

  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_HI = 4'd4;
  localparam logic [3:0] COND_LS = 4'd5;
  localparam logic [3:0] COND_GT = 4'd6;
  localparam logic [3:0] COND_LE = 4'd7;
  localparam logic [3:0] COND_FS = 4'd8;
  localparam logic [3:0] COND_FC = 4'd9;
  localparam logic [3:0] COND_LO = 4'd10;
  localparam logic [3:0] COND_HS = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GE = 4'd13;
  localparam logic [3:0] COND_UC = 4'd14;

  // Immediate opcodes share their encoding with the register-form ext codes.
  function automatic logic [3:0] aluLookup(input logic [3:0] opcode, input logic [3:0] ext);
    logic [3:0] code;
    code = (opcode == OP_RTYPE) ? ext : opcode;
    case (code)
      OP_ADDI: return ALU_ADD;
      OP_SUBI: return ALU_SUB;
      OP_CMPI: return ALU_CMP;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_XORI: return ALU_XOR;
      OP_MOVI: return ALU_MOV;
      OP_LUI:  return ALU_LUI;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/cr16_control_fsm_cond_eval.sv
// cr16_cond_eval: combinational CR16 branch/jump condition evaluation against the PSR
module cr16_cond_eval
  import cr16_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [7:0] psr,
  output logic       taken
);

  logic c, l, f, z, n, unusedPsr;

  assign {c, l, f, z, n} = {psr[PSR_C], psr[PSR_L], psr[PSR_F], psr[PSR_Z], psr[PSR_N]};
  assign unusedPsr = ^{psr[4:3], psr[1]};

  always_comb
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_HI: taken = l;
      COND_LS: taken = !l;
      COND_GT: taken = n;
      COND_LE: taken = !n;
      COND_FS: taken = f;
      COND_FC: taken = !f;
      COND_LO: taken = !l && !z;
      COND_HS: taken = l || z;
      COND_LT: taken = !n && !z;
      COND_GE: taken = n || z;
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase

endmodule

// File: rtl/cr16_control_fsm.sv
// cr16_control_fsm: multicycle fetch/decode/execute/memory/write-back sequencer for the CR16 datapath.
// Define CTRL_MEMWAIT_EN to stall FETCH, MEM_LOAD and MEM_STORE until memReady.
module cr16_control_fsm
  import cr16_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   instrOut,
  input  logic [7:0]         PSROut,
  input  logic               memReady,
  output logic               memWrite,
  output logic               PCEN,
  output logic               PSREN,
  output logic               nextInstruction,
  output logic               updateAddress,
  output logic               StoreReg,
  output logic               WriteData,
  output logic               regWrite,
  output logic               ZeroExtend,
  output logic               PCinstruction,
  output logic               SrcB,
  output logic               regDest,
  output logic               resultEn,
  output logic               immediateRegEN,
  output logic               jumpEN,
  output logic               BranchEN,
  output logic               jalEN,
  output logic [REGBITS-1:0] shiftAmt,
  output logic [REGBITS-1:0] shifterControl,
  output logic [REGBITS-1:0] ALUcond,
  output logic [1:0]         chooseResult
);

  stateT state;
  logic [3:0] opcode, rdest, ext, aluOp;
  logic isMem, isLoad, isStore, isJal, isJcond, isBcond, isShift, isAlu, isCmp, setsFlags;
  logic taken, memOk;

  assign opcode    = instrOut[15:12];
  assign rdest     = instrOut[11:8];
  assign ext       = instrOut[7:4];
  assign aluOp     = aluLookup(opcode, ext);
  assign isMem     = opcode == OP_MEM;
  assign isLoad    = isMem && ext == EXT_LOAD;
  assign isStore   = isMem && ext == EXT_STOR;
  assign isJal     = isMem && ext == EXT_JAL;
  assign isJcond   = isMem && ext == EXT_JCOND;
  assign isBcond   = opcode == OP_BCOND;
  assign isShift   = opcode == OP_SHIFT;
  assign isAlu     = opcode == OP_RTYPE || aluOp != ALU_NOP;
  assign isCmp     = aluOp == ALU_CMP;
  assign setsFlags = aluOp == ALU_ADD || aluOp == ALU_SUB || aluOp == ALU_CMP;

`ifdef CTRL_MEMWAIT_EN
  assign memOk = memReady;
`else
  logic unusedMemReady;
  assign unusedMemReady = memReady;
  assign memOk = 1'b1;
`endif

  cr16_cond_eval u_cond (
    .cond  (isBcond ? ext : rdest),
    .psr   (PSROut),
    .taken (taken)
  );

  always_ff @(posedge clk)
    if (!reset) state <= FETCH;
    else
      case (state)
        FETCH:     state <= memOk ? DECODE : FETCH;
        DECODE:    state <= isAlu ? EX_ALU : isShift ? EX_SHIFT : isLoad ? MEM_LOAD : isStore ? MEM_STORE : PC_UPD;
        EX_ALU:    state <= isCmp ? PC_UPD : WB_REG;
        EX_SHIFT:  state <= WB_REG;
        MEM_LOAD:  state <= memOk ? WB_LOAD : MEM_LOAD;
        MEM_STORE: state <= memOk ? PC_UPD : MEM_STORE;
        WB_REG:    state <= PC_UPD;
        WB_LOAD:   state <= PC_UPD;
        default:   state <= FETCH;
      endcase

  // Gating on reset itself keeps a mid-instruction reset from committing anything in its first cycle.
  always_comb begin
    {memWrite, PCEN, PSREN, nextInstruction, updateAddress, StoreReg, WriteData, regWrite,
     ZeroExtend, PCinstruction, SrcB, regDest, resultEn, immediateRegEN, jumpEN, BranchEN, jalEN} = '0;
    shiftAmt       = '0;
    shifterControl = '0;
    ALUcond        = '0;
    chooseResult   = 2'd0;
    if (reset)
      case (state)
        FETCH: begin
          updateAddress   = 1'b1;
          nextInstruction = 1'b1;
        end
        DECODE: begin
          immediateRegEN = 1'b1;
          ZeroExtend     = opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI;
          regDest        = isBcond || isJcond || isJal;
        end
        EX_ALU: begin
          resultEn     = 1'b1;
          chooseResult = 2'd1;
          SrcB         = opcode == OP_RTYPE;
          ALUcond      = aluOp;
          PSREN        = setsFlags;
        end
        EX_SHIFT: begin
          resultEn       = 1'b1;
          shifterControl = ext;
          shiftAmt       = instrOut[3:0];
        end
        MEM_STORE: begin
          StoreReg = 1'b1;
          memWrite = 1'b1;
        end
        WB_REG: begin
          WriteData = 1'b1;
          regWrite  = 1'b1;
        end
        WB_LOAD: regWrite = 1'b1;
        PC_UPD: begin
          PCEN          = 1'b1;
          BranchEN      = isBcond && taken;
          PCinstruction = isBcond && taken;
          jumpEN        = isJcond && taken;
          jalEN         = isJal;
          regWrite      = isJal;
          regDest       = isJal;
          chooseResult  = isJal ? 2'd3 : 2'd0;
        end
        default: ;
      endcase
  end

endmodule
